// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: mid-bit start qualification, optional parity, one or two
// stop bits, and a valid/ready output register with overrun reporting.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rs232,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1   = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic                   stop_q, stop_d;
  logic [DATA_BITS-1:0]   sh_q, sh_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   pe_out_q, pe_out_d;
  logic                   fe_out_q, fe_out_d;
  logic                   ovr_q, ovr_d;
  logic                   line;
  logic                   mid;
  logic                   done;

  assign line = sync_q[SYNC_STAGES-1];
  assign mid  = (cnt_q == FULL_M1);

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], rs232};
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    bit_d    = bit_q;
    stop_d   = stop_q;
    sh_d     = sh_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    data_d   = data_q;
    valid_d  = valid_q;
    pe_out_d = pe_out_q;
    fe_out_d = fe_out_q;
    ovr_d    = 1'b0;
    done     = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!line) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (line) begin
            state_d = S_IDLE;
          end else begin
            bit_d   = '0;
            stop_d  = 1'b0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (mid) begin
          cnt_d = '0;
          sh_d  = {line, sh_q[DATA_BITS-1:1]};
          bit_d = bit_q + 1'b1;
          if (bit_q == LAST_BIT) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (mid) begin
          cnt_d   = '0;
          // xor of data and parity bit is 1 for a good odd frame, 0 for a good even one
          perr_d  = (^{sh_q, line}) ^ ODD;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (mid) begin
          cnt_d  = '0;
          stop_d = ~stop_q;
          if (!line) ferr_d = 1'b1;
          if (stop_q == STOP_LAST) begin
            done    = 1'b1;
            state_d = line ? S_IDLE : S_BREAK;
          end
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (line) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (valid_q && rx_ready) valid_d = 1'b0;

    // a held, unaccepted word wins over the new frame
    if (done) begin
      if (!valid_q || rx_ready) begin
        data_d   = sh_q;
        pe_out_d = perr_q;
        fe_out_d = ferr_q | ~line;
        valid_d  = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sync_q   <= '1;
      cnt_q    <= '0;
      bit_q    <= '0;
      stop_q   <= 1'b0;
      sh_q     <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      pe_out_q <= 1'b0;
      fe_out_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
      sh_q     <= sh_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      pe_out_q <= pe_out_d;
      fe_out_q <= fe_out_d;
      ovr_q    <= ovr_d;
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign parity_err = pe_out_q;
  assign frame_err  = fe_out_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: three configurations (8N1, 8E1, 7N2) on separate lines.
module tb_uart_rx_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic line_a = 1'b1, line_b = 1'b1, line_c = 1'b1;
  logic ready_a = 1'b1, ready_b = 1'b1, ready_c = 1'b1;

  logic [7:0] data_a, data_b;
  logic [6:0] data_c;
  logic valid_a, perr_a, ferr_a, ovr_a, busy_a;
  logic valid_b, perr_b, ferr_b, ovr_b, busy_b;
  logic valid_c, perr_c, ferr_c, ovr_c, busy_c;

  uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(2)) u_a (
    .clk(clk), .rst_n(rst_n), .rs232(line_a), .rx_data(data_a), .rx_valid(valid_a),
    .rx_ready(ready_a), .parity_err(perr_a), .frame_err(ferr_a), .overrun(ovr_a), .busy(busy_a));

  uart_rx_param #(.CLKS_PER_BIT(8), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .SYNC_STAGES(2)) u_b (
    .clk(clk), .rst_n(rst_n), .rs232(line_b), .rx_data(data_b), .rx_valid(valid_b),
    .rx_ready(ready_b), .parity_err(perr_b), .frame_err(ferr_b), .overrun(ovr_b), .busy(busy_b));

  uart_rx_param #(.CLKS_PER_BIT(8), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .SYNC_STAGES(2)) u_c (
    .clk(clk), .rst_n(rst_n), .rs232(line_c), .rx_data(data_c), .rx_valid(valid_c),
    .rx_ready(ready_c), .parity_err(perr_c), .frame_err(ferr_c), .overrun(ovr_c), .busy(busy_c));

  typedef struct packed {
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t q_a[$], q_b[$], q_c[$];
  exp_t e_a, e_b, e_c;
  int n_checks = 0;
  int n_pass   = 0;
  int ovr_cnt_a = 0, ovr_cnt_b = 0, ovr_cnt_c = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic push(input int w, input logic [8:0] d, input logic pe, input logic fe);
    exp_t e;
    e.d = d; e.pe = pe; e.fe = fe;
    case (w)
      0:       q_a.push_back(e);
      1:       q_b.push_back(e);
      default: q_c.push_back(e);
    endcase
  endtask

  task automatic set_line(input int w, input logic v);
    case (w)
      0:       line_a = v;
      1:       line_b = v;
      default: line_c = v;
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Line is left at the value of the last stop bit.
  task automatic send(input int w, input int cpb, input logic [8:0] data, input int dbits,
                      input int par, input logic pbit, input int nstop, input logic [1:0] stops);
    set_line(w, 1'b0); idle(cpb);
    for (int i = 0; i < dbits; i++) begin set_line(w, data[i]); idle(cpb); end
    if (par != 0) begin set_line(w, pbit); idle(cpb); end
    for (int i = 0; i < nstop; i++) begin set_line(w, stops[i]); idle(cpb); end
  endtask

  always @(negedge clk) begin
    if (rst_n && valid_a && ready_a) begin
      if (q_a.size() == 0) chk("a_unexpected_word", {24'd0, data_a}, 32'hFFFF_FFFF);
      else begin
        e_a = q_a.pop_front();
        chk("a_data", {24'd0, data_a}, {23'd0, e_a.d});
        chk("a_parity_err", {31'd0, perr_a}, {31'd0, e_a.pe});
        chk("a_frame_err", {31'd0, ferr_a}, {31'd0, e_a.fe});
      end
    end
    if (ovr_a) ovr_cnt_a++;
  end

  always @(negedge clk) begin
    if (rst_n && valid_b && ready_b) begin
      if (q_b.size() == 0) chk("b_unexpected_word", {24'd0, data_b}, 32'hFFFF_FFFF);
      else begin
        e_b = q_b.pop_front();
        chk("b_data", {24'd0, data_b}, {23'd0, e_b.d});
        chk("b_parity_err", {31'd0, perr_b}, {31'd0, e_b.pe});
        chk("b_frame_err", {31'd0, ferr_b}, {31'd0, e_b.fe});
      end
    end
    if (ovr_b) ovr_cnt_b++;
  end

  always @(negedge clk) begin
    if (rst_n && valid_c && ready_c) begin
      if (q_c.size() == 0) chk("c_unexpected_word", {25'd0, data_c}, 32'hFFFF_FFFF);
      else begin
        e_c = q_c.pop_front();
        chk("c_data", {25'd0, data_c}, {23'd0, e_c.d});
        chk("c_parity_err", {31'd0, perr_c}, {31'd0, e_c.pe});
        chk("c_frame_err", {31'd0, ferr_c}, {31'd0, e_c.fe});
      end
    end
    if (ovr_c) ovr_cnt_c++;
  end

  initial begin
    int bc;
    rst_n = 1'b0;
    idle(3);
    chk("rst_data", {24'd0, data_a}, 32'd0);
    chk("rst_valid", {31'd0, valid_a}, 32'd0);
    chk("rst_flags", {29'd0, perr_a, ferr_a, ovr_a}, 32'd0);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    rst_n = 1'b1;
    idle(5);

    // 8N1 clean word
    push(0, 9'h0A5, 1'b0, 1'b0);
    send(0, 16, 9'h0A5, 8, 0, 1'b0, 1, 2'b11);
    idle(32);
    chk("t1_valid_dropped", {31'd0, valid_a}, 32'd0);
    chk("t1_no_overrun", ovr_cnt_a, 32'd0);

    // 4-clk glitch: START lasts HALF cycles, then back to IDLE
    bc = 0;
    line_a = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 3) line_a = 1'b1;
      if (busy_a) bc++;
    end
    chk("t2_glitch_busy_cycles", bc, 32'd8);
    chk("t2_glitch_no_valid", {31'd0, valid_a}, 32'd0);

    // even parity
    push(1, 9'h007, 1'b0, 1'b0);
    send(1, 8, 9'h007, 8, 2, 1'b1, 1, 2'b11);
    idle(16);
    push(1, 9'h007, 1'b1, 1'b0);
    send(1, 8, 9'h007, 8, 2, 1'b0, 1, 2'b11);
    idle(16);

    // bad stop bit followed by a long break
    push(0, 9'h055, 1'b0, 1'b1);
    send(0, 16, 9'h055, 8, 0, 1'b0, 1, 2'b00);
    idle(40 * 16);
    chk("t4_break_busy", {31'd0, busy_a}, 32'd1);
    line_a = 1'b1;
    idle(32);
    chk("t4_break_released", {31'd0, busy_a}, 32'd0);
    push(0, 9'h03C, 1'b0, 1'b0);
    send(0, 16, 9'h03C, 8, 0, 1'b0, 1, 2'b11);
    idle(32);

    // overrun with consumer stalled
    ready_a = 1'b0;
    push(0, 9'h011, 1'b0, 1'b0);
    send(0, 16, 9'h011, 8, 0, 1'b0, 1, 2'b11);
    send(0, 16, 9'h022, 8, 0, 1'b0, 1, 2'b11);
    idle(32);
    chk("t5_held_data", {24'd0, data_a}, 32'h11);
    chk("t5_held_valid", {31'd0, valid_a}, 32'd1);
    chk("t5_overrun_cycles", ovr_cnt_a, 32'd1);
    ready_a = 1'b1;
    idle(4);
    chk("t5_valid_after_accept", {31'd0, valid_a}, 32'd0);
    chk("t5_data_after_accept", {24'd0, data_a}, 32'h11);

    // reset during data bit 3 of 0xF0
    line_a = 1'b0; idle(16);
    for (int i = 0; i < 3; i++) begin line_a = 1'b0; idle(16); end
    line_a = 1'b0; idle(8);
    chk("t6_busy_midframe", {31'd0, busy_a}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", {31'd0, busy_a}, 32'd0);
    chk("t6_rst_data", {24'd0, data_a}, 32'd0);
    chk("t6_rst_valid", {31'd0, valid_a}, 32'd0);
    chk("t6_rst_flags", {29'd0, perr_a, ferr_a, ovr_a}, 32'd0);
    line_a = 1'b1;
    idle(10);
    rst_n = 1'b1;
    idle(10);
    push(0, 9'h03C, 1'b0, 1'b0);
    send(0, 16, 9'h03C, 8, 0, 1'b0, 1, 2'b11);
    idle(32);

    // 7 data bits, 2 stop bits
    push(2, 9'h05A, 1'b0, 1'b0);
    send(2, 8, 9'h05A, 7, 0, 1'b0, 2, 2'b11);
    idle(16);
    push(2, 9'h015, 1'b0, 1'b1);
    send(2, 8, 9'h015, 7, 0, 1'b0, 2, 2'b01);
    line_c = 1'b1;
    idle(24);

    chk("end_q_a_empty", q_a.size(), 32'd0);
    chk("end_q_b_empty", q_b.size(), 32'd0);
    chk("end_q_c_empty", q_c.size(), 32'd0);
    chk("end_overrun_a", ovr_cnt_a, 32'd1);
    chk("end_overrun_b", ovr_cnt_b, 32'd0);
    chk("end_overrun_c", ovr_cnt_c, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver: serial line to parallel words, with configurable bit period, data width, parity and stop bits. Start bits are qualified at mid-bit, so glitches do not start a frame. Parity and framing errors are reported alongside the data. Output uses a valid/ready handshake with overrun detection, so it can feed a FIFO or a bus register directly.

Parameters:
CLKS_PER_BIT, 16, clk cycles per bit period; legal range >= 4.
DATA_BITS, 8, data bits per frame; legal range 5..9; LSB first.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, 1 or 2.
SYNC_STAGES, 2, input synchroniser depth; minimum 2.

Ports:
clk  in  1  clock
rst_n  in  1  reset: asynchronous, active-low
rs232  in  1  asynchronous serial line; idle high
rx_data  out  DATA_BITS  received word; stable while rx_valid=1
rx_valid  out  1  word available; held until accepted
rx_ready  in  1  consumer accepts when rx_valid & rx_ready
parity_err  out  1  parity mismatch for the held word; qualified by rx_valid
frame_err  out  1  a stop bit sampled 0 for the held word; qualified by rx_valid
overrun  out  1  one-cycle pulse: completed frame dropped
busy  out  1  high in any state except IDLE

Behaviour:
- Reset: synchroniser = all 1s; FSM = IDLE; all counters 0; rx_data = 0; rx_valid, parity_err, frame_err, overrun, busy = 0.
- Reset mid-frame aborts the frame. No partial word is ever presented.
- All decisions use the last synchroniser stage ("line"). The bit counter is $clog2(CLKS_PER_BIT) bits wide.
- HALF = CLKS_PER_BIT/2 (integer division).
- IDLE: when line == 0, go to START and clear the counter.
- START: when the counter reaches HALF-1, resample the line.
  - line == 1: false start; go to IDLE with no outputs.
  - line == 0: clear the counter and go to DATA.
- DATA: sample each bit when the counter reaches CLKS_PER_BIT-1 (mid-bit); clear the counter on each sample.
  - Shift each sample into the MSB of the shift register (LSB-first arrival).
  - After DATA_BITS samples: go to PARITY if PARITY != 0, else STOP.
- PARITY: one sample at the same mid-bit point.
  - Odd mode: error if XOR(data, parity bit) == 0.
  - Even mode: error if XOR(data, parity bit) == 1.
- STOP: take STOP_BITS samples, each at mid-bit. Any sample == 0 sets the frame's frame error.
  - The cycle after the last stop sample, the frame is delivered (see handshake).
  - Then: if the last stop sample was 1, go to IDLE, which allows re-arming inside the stop bit.
  - Otherwise go to BREAK_WAIT.
- BREAK_WAIT: stay until line == 1, then go to IDLE. A held-low line (break) therefore yields exactly one frame, flagged frame_err=1.
- Handshake / delivery at frame completion:
  - rx_valid == 0, or rx_valid & rx_ready in the same cycle: load rx_data, parity_err, frame_err together; rx_valid = 1. No overrun.
  - rx_valid == 1 & rx_ready == 0: keep the old word and flags; drop the new frame; overrun = 1 for exactly one cycle.
- Acceptance with no completion: rx_valid & rx_ready clears rx_valid on the next edge. rx_data holds its last value.
- Latency: rx_valid rises 1 clk after the final stop-bit mid-sample.
  - That sample falls at (1 + DATA_BITS + P + STOP_BITS - 0.5) * CLKS_PER_BIT clks after the line falling edge, plus SYNC_STAGES clks. P = 1 if PARITY != 0, else 0.
- Frames with errors are still delivered. Flags are meaningful only while rx_valid = 1.

Test Plan:
1. CLKS_PER_BIT=16, 8N1; send 0xA5 with rx_ready=1 -> rx_data=0xA5, rx_valid high for 1 cycle, parity_err=0, frame_err=0, overrun never pulses.
2. Line pulses low for 4 clks, then idles -> FSM returns to IDLE after the START check; rx_valid stays 0; busy is high for about HALF cycles only.
3. PARITY=2, 8 data bits; send 0x07 with parity bit 1 -> parity_err=0. Resend 0x07 with parity bit 0 -> rx_data=0x07, parity_err=1.
4. Send 0x55 with stop bit 0, then hold the line low for 40 bit times, then release -> exactly one frame: rx_data=0x55, frame_err=1. No new frame until the line goes high, then the next frame 0x3C is received cleanly.
5. rx_ready=0; send 0x11 then 0x22 back-to-back -> rx_data stays 0x11, overrun pulses for 1 cycle at the second completion. Then raise rx_ready -> 0x11 is accepted and rx_valid drops.
6. Assert rst_n low during data bit 3 of 0xF0 -> all outputs 0 immediately. After release, send 0x3C -> rx_data=0x3C, no error flags. Repeat with DATA_BITS=7, STOP_BITS=2, 0x5A -> rx_data=0x5A.
